instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/i4004_pkg.sv | 42 ++++
 rtl/instr_fetch.sv | 185 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i4004_pkg.sv
// i4004_pkg: shared definitions for the 4004-style fetch path.
// Holds the address width, the opcode (opr nibble) constants that select
// two-byte instructions, the fetch state enum and the length decoder.
package i4004_pkg;

    // ROM byte address width: {page[3:0], offset[7:0]}
    localparam int ADDR_W = 12;

    // opr nibbles of the two-byte instruction families
    localparam logic [3:0] OPR_JCN = 4'h1;
    localparam logic [3:0] OPR_FIM = 4'h2;
    localparam logic [3:0] OPR_JUN = 4'h4;
    localparam logic [3:0] OPR_JMS = 4'h5;
    localparam logic [3:0] OPR_ISZ = 4'h7;

    // Fetch sequencer states. The encoding is visible on the state signal
    // of instr_fetch so checkers can bind to it.
    typedef enum logic [2:0] {
        S_REQ1  = 3'd0,
        S_WAIT1 = 3'd1,
        S_REQ2  = 3'd2,
        S_WAIT2 = 3'd3,
        S_OUT   = 3'd4,
        S_DRAIN = 3'd5
    } fetch_state_t;

    // True when the first byte starts a two-byte instruction. The opr
    // 0010 group is shared by FIM (opa[0]=0) and SRC (opa[0]=1); only
    // FIM carries an operand byte.
    function automatic logic is_two_byte(input logic [7:0] first_byte);
        logic [3:0] opr;
        logic [3:0] opa;
        opr = first_byte[7:4];
        opa = first_byte[3:0];
        case (opr)
            OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: is_two_byte = 1'b1;
            OPR_FIM:                            is_two_byte = ~opa[0];
            default:                            is_two_byte = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: byte-wide instruction fetch for a 4004-style core.
// Reads one- or two-byte instructions from a 12-bit ROM over a req/ack
// interface, presents them to the executor, and follows jump/skip redirects.
// Build option: define FETCH_BITREV_EN to bit-reverse every ROM byte
// (bit7<->bit0, bit6<->bit1, ...) before decode and operand capture.
//
// Handshakes:
//   ROM side  - rom_req rises with rom_addr already stable and stays high,
//               with rom_addr unchanged, up to and including the cycle in
//               which rom_ack pulses; rom_data is sampled only in that cycle.
//   Exec side - instr_valid holds with all instr_* stable until a cycle in
//               which instr_ready is also high; the instruction is consumed
//               on that rising edge and never presented again.
module instr_fetch
    import i4004_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_req,
    input  logic              rom_ack,
    input  logic [7:0]        rom_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [3:0]        instr_opr,
    output logic [3:0]        instr_opa,
    output logic [7:0]        instr_arg,
    output logic              instr_len2,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              fetch_busy
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [7:0]        fetch_byte;
    logic              ack_first;
    logic              ack_second;
    logic              ack_any;
    logic              issue;

    // Byte conditioning ahead of decode and operand capture
`ifdef FETCH_BITREV_EN
    for (genvar i = 0; i < 8; i++) begin : g_bitrev
        assign fetch_byte[i] = rom_data[7-i];
    end
`else
    assign fetch_byte = rom_data;
`endif

    // An ack only counts while a request is outstanding; acks seen in any
    // other state (e.g. a stale one right after reset) are ignored.
    assign ack_first  = (state == S_WAIT1) && rom_ack;
    assign ack_second = (state == S_WAIT2) && rom_ack;
    assign ack_any    = ack_first || ack_second;

    // A request is launched from a REQ state unless a redirect arrives in
    // the same cycle, in which case the launch is retried at the new pc.
    assign issue = ((state == S_REQ1) || (state == S_REQ2)) && !redirect_valid;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_REQ1;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A redirect abandons whatever is being fetched; if
    // the ROM still owes an ack the fetch parks in S_DRAIN to absorb it.
    always_comb begin
        state_next = state;
        case (state)
            S_REQ1: begin
                if (!redirect_valid) begin
                    state_next = S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (rom_ack) begin
                    if (redirect_valid) begin
                        state_next = S_REQ1;
                    end else if (is_two_byte(fetch_byte)) begin
                        state_next = S_REQ2;
                    end else begin
                        state_next = S_OUT;
                    end
                end else if (redirect_valid) begin
                    state_next = S_DRAIN;
                end
            end
            S_REQ2: begin
                state_next = redirect_valid ? S_REQ1 : S_WAIT2;
            end
            S_WAIT2: begin
                if (rom_ack) begin
                    state_next = redirect_valid ? S_REQ1 : S_OUT;
                end else if (redirect_valid) begin
                    state_next = S_DRAIN;
                end
            end
            S_OUT: begin
                // Acceptance and redirect both lead back to a fresh fetch;
                // pc already holds the right address for either case.
                if (instr_ready || redirect_valid) begin
                    state_next = S_REQ1;
                end
            end
            S_DRAIN: begin
                if (rom_ack) begin
                    state_next = S_REQ1;
                end
            end
            default: begin
                state_next = S_REQ1;
            end
        endcase
    end

    // Outputs decoded from the state register only
    always_comb begin
        rom_req     = 1'b0;
        instr_valid = 1'b0;
        case (state)
            S_WAIT1, S_WAIT2, S_DRAIN: rom_req     = 1'b1;
            S_OUT:                     instr_valid = 1'b1;
            default: ;
        endcase
    end

    assign fetch_busy = rom_req;
    assign rom_addr   = rom_addr_q;

    // ROM address register: frozen for the life of a request, so a
    // redirect during S_DRAIN cannot disturb the address the ROM sees.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rom_addr_q <= '0;
        end else if (issue) begin
            rom_addr_q <= pc;
        end
    end

    // Program counter: a redirect wins over the post-ack increment, and the
    // last redirect seen wins. Arithmetic wraps modulo 4096.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc <= '0;
        end else if (redirect_valid) begin
            pc <= redirect_addr;
        end else if (ack_any) begin
            pc <= pc + PC_STEP;
        end
    end

    // Instruction register: loaded only by acks of a live fetch, so it is
    // naturally stable while S_OUT waits for the executor.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            instr_opr  <= 4'h0;
            instr_opa  <= 4'h0;
            instr_arg  <= 8'h00;
            instr_len2 <= 1'b0;
            instr_pc   <= '0;
        end else if (!redirect_valid) begin
            if (ack_first) begin
                instr_opr  <= fetch_byte[7:4];
                instr_opa  <= fetch_byte[3:0];
                instr_arg  <= 8'h00;
                instr_len2 <= 1'b0;
                instr_pc   <= pc;
            end else if (ack_second) begin
                instr_arg  <= fetch_byte;
                instr_len2 <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: random and directed bench for instr_fetch with a ROM
// responder, an executor driver and a scoreboard fed by a reference model
// that walks the ROM image instruction by instruction.
`timescale 1ns/1ps
module tb_instr_fetch;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RESET;
  logic [11:0] rom_addr;
  logic        rom_req;
  logic        rom_ack;
  logic [7:0]  rom_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_opr;
  logic [3:0]  instr_opa;
  logic [7:0]  instr_arg;
  logic        instr_len2;
  logic [11:0] instr_pc;
  logic        redirect_valid;
  logic [11:0] redirect_addr;
  logic        fetch_busy;

  always #5 CLK = ~CLK;

  instr_fetch dut (
    .CLK(CLK), .RESET(RESET),
    .rom_addr(rom_addr), .rom_req(rom_req), .rom_ack(rom_ack), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opr(instr_opr), .instr_opa(instr_opa), .instr_arg(instr_arg),
    .instr_len2(instr_len2), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .fetch_busy(fetch_busy)
  );

  // ---------------- shared state ----------------
  logic [7:0]  mem [0:4095];
  logic [28:0] exp_q[$];          // {opr, opa, arg, len2, pc}
  logic [11:0] model_pc;
  int          n_checks = 0;
  int          n_fail = 0;
  int          lat_fixed = 0;     // -1 selects a random latency 0..lat_max
  int          lat_max = 3;
  bit          inject_stray = 0;
  bit          rand_exec = 0;
  int          handshakes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] cond_byte(input logic [7:0] b);
    logic [7:0] r;
`ifdef FETCH_BITREV_EN
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
    r = b;
`endif
    return r;
  endfunction

  // Instruction that starts at address a, and the address after it.
  function automatic logic [28:0] model_instr(input logic [11:0] a, output logic [11:0] nxt);
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [11:0] a1;
    logic        two;
    b0  = cond_byte(mem[a]);
    a1  = a + 12'd1;
    two = (b0[7:4] == 4'h1) || (b0[7:4] == 4'h4) || (b0[7:4] == 4'h5) ||
          (b0[7:4] == 4'h7) || ((b0[7:4] == 4'h2) && (b0[0] == 1'b0));
    b1  = two ? cond_byte(mem[a1]) : 8'h00;
    nxt = two ? a1 + 12'd1 : a1;
    return {b0[7:4], b0[3:0], b1, two, a};
  endfunction

  task automatic push_expect(input logic [11:0] a);
    logic [11:0] nxt;
    exp_q.push_back(model_instr(a, nxt));
    model_pc = nxt;
  endtask

  // ---------------- ROM responder ----------------
  bit          in_req = 0;
  int          lat_cnt = 0;
  logic [11:0] req_addr;

  always begin
    @(negedge CLK); #1;
    if (RESET) begin
      rom_ack = 1'b0;
      in_req  = 0;
    end else begin
      rom_ack  = 1'b0;
      rom_data = 8'($urandom);
      if (inject_stray) begin
        rom_ack      = 1'b1;
        rom_data     = 8'hFF;
        inject_stray = 0;
      end else if (rom_req) begin
        if (!in_req) begin
          in_req   = 1;
          req_addr = rom_addr;
          lat_cnt  = (lat_fixed >= 0) ? lat_fixed : $urandom_range(lat_max, 0);
        end else begin
          check("rom_addr_stable", 32'(rom_addr), 32'(req_addr));
        end
        if (lat_cnt == 0) begin
          rom_ack  = 1'b1;
          rom_data = mem[rom_addr];
          in_req   = 0;
        end else begin
          lat_cnt--;
        end
      end else if (in_req) begin
        check("rom_req_held_until_ack", 32'(rom_req), 32'd1);
        in_req = 0;
      end
    end
  end

  // ---------------- executor driver (random mode) ----------------
  always begin
    @(negedge CLK); #1;
    if (rand_exec && !RESET) begin
      instr_ready    = ($urandom_range(9, 0) < 7);
      redirect_valid = ($urandom_range(99, 0) < 4);
      redirect_addr  = 12'($urandom);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [28:0] mon_act;
  logic [28:0] mon_held;
  logic [28:0] mon_exp;
  bit          hold_chk = 0;
  bit          drop_chk = 0;

  always begin
    @(negedge CLK); #2;
    if (RESET) begin
      hold_chk = 0;
      drop_chk = 0;
    end else begin
      mon_act = {instr_opr, instr_opa, instr_arg, instr_len2, instr_pc};
      check("fetch_busy_eq_rom_req", 32'(fetch_busy), 32'(rom_req));
      if (hold_chk) begin
        check("valid_held", 32'(instr_valid), 32'd1);
        check("instr_held", 32'(mon_act), 32'(mon_held));
      end
      if (drop_chk) check("valid_dropped_after_redirect", 32'(instr_valid), 32'd0);
      if (instr_valid && instr_ready) begin
        handshakes++;
        if (exp_q.size() == 0) begin
          check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
          mon_exp = exp_q.pop_front();
          check("instr_out", 32'(mon_act), 32'(mon_exp));
        end
      end
      hold_chk = instr_valid && !instr_ready && !redirect_valid;
      drop_chk = redirect_valid;
      mon_held = mon_act;
      if (redirect_valid) begin
        exp_q.delete();
        push_expect(redirect_addr);
      end else if (instr_valid && instr_ready) begin
        push_expect(model_pc);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_req"},    32'(rom_req), 32'd0);
    check({tag, "_rom_addr"},   32'(rom_addr), 32'd0);
    check({tag, "_fetch_busy"}, 32'(fetch_busy), 32'd0);
    check({tag, "_valid"},      32'(instr_valid), 32'd0);
    check({tag, "_instr"},      32'({instr_opr, instr_opa, instr_arg, instr_len2, instr_pc}), 32'd0);
  endtask

  task automatic enter_reset();
    @(negedge CLK);
    RESET = 1'b1;
    rand_exec = 0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  // Leave reset and steer the first fetch to address a with a redirect.
  task automatic release_at(input logic [11:0] a);
    RESET = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr = a;
    @(negedge CLK);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit, input string name);
    int k = 0;
    while (!instr_valid && k < limit) begin
      @(negedge CLK);
      k++;
    end
    if (!instr_valid) check({name, "_timeout"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_req(input int limit, input string name);
    int k = 0;
    while (!rom_req && k < limit) begin
      @(negedge CLK);
      k++;
    end
    if (!rom_req) check({name, "_timeout"}, 32'(rom_req), 32'd1);
  endtask

  task automatic check_instr(input string name, input logic [28:0] exp);
    check(name, 32'({instr_opr, instr_opa, instr_arg, instr_len2, instr_pc}), 32'(exp));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int gap;
    RESET = 1'b1;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    rom_ack = 1'b0;
    rom_data = 8'h00;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

    // Reset values, stray ack after reset, first request timing, LDM 5
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    mem[12'h000] = 8'hD5;
    mem[12'h001] = 8'hD6;
    lat_fixed = 0;
    exp_q.delete();
    push_expect(12'h000);
    RESET = 1'b0;
    inject_stray = 1;
    check("rom_req_cycle1", 32'(rom_req), 32'd0);
    @(negedge CLK);
    check("rom_req_cycle2", 32'(rom_req), 32'd1);
    check("rom_addr_first", 32'(rom_addr), 32'h000);
    wait_valid(20, "ldm");
    check_instr("ldm5", {4'hD, 4'h5, 8'h00, 1'b0, 12'h000});
    gap = 0;
    do begin
      @(negedge CLK);
      gap++;
    end while (!instr_valid && gap < 10);
    check("one_byte_cost_cycles", 32'(gap), 32'd3);
    check_instr("ldm6", {4'hD, 4'h6, 8'h00, 1'b0, 12'h001});

    // JUN at 0x010 with 3-cycle ack latency
    enter_reset();
    mem[12'h010] = 8'h40;
    mem[12'h011] = 8'h23;
    lat_fixed = 3;
    release_at(12'h010);
    wait_valid(40, "jun");
    check_instr("jun", {4'h4, 4'h0, 8'h23, 1'b1, 12'h010});
    @(negedge CLK);
    wait_req(20, "jun_next");
    check("jun_next_addr", 32'(rom_addr), 32'h012);

    // Executor stalls for 10 cycles
    enter_reset();
    mem[12'h100] = 8'hD3;
    lat_fixed = 1;
    instr_ready = 1'b0;
    release_at(12'h100);
    wait_valid(20, "stall");
    for (int i = 0; i < 10; i++) begin
      check("stall_rom_req_low", 32'(rom_req), 32'd0);
      check_instr("stall_instr", {4'hD, 4'h3, 8'h00, 1'b0, 12'h100});
      @(negedge CLK);
    end
    instr_ready = 1'b1;
    @(negedge CLK);
    wait_req(20, "stall_next");
    check("stall_next_addr", 32'(rom_addr), 32'h101);

    // Redirect during S_WAIT1, ack two cycles later
    enter_reset();
    mem[12'h200] = 8'hD1;
    mem[12'h3A0] = 8'hD7;
    lat_fixed = 2;
    release_at(12'h200);
    wait_req(20, "drain");
    redirect_valid = 1'b1;
    redirect_addr = 12'h3A0;
    @(negedge CLK);
    redirect_valid = 1'b0;
    while (rom_req && gap < 100) begin
      @(negedge CLK);
      gap++;
    end
    wait_req(20, "drain_next");
    check("drain_next_addr", 32'(rom_addr), 32'h3A0);
    wait_valid(20, "drain_out");
    check_instr("drain_out", {4'hD, 4'h7, 8'h00, 1'b0, 12'h3A0});

    // JCN at 0xFFF takes its operand from 0x000
    enter_reset();
    mem[12'hFFF] = 8'h1A;
    mem[12'h000] = 8'h5C;
    lat_fixed = -1;
    release_at(12'hFFF);
    wait_valid(40, "wrap");
    check_instr("wrap_jcn", {4'h1, 4'hA, 8'h5C, 1'b1, 12'hFFF});
    @(negedge CLK);
    wait_req(20, "wrap_next");
    check("wrap_next_addr", 32'(rom_addr), 32'h001);

    // Redirect in the same cycle as acceptance
    enter_reset();
    mem[12'h300] = 8'hD2;
    mem[12'h050] = 8'hDE;
    release_at(12'h300);
    wait_valid(40, "accept_redir");
    redirect_valid = 1'b1;
    redirect_addr = 12'h050;
    @(negedge CLK);
    redirect_valid = 1'b0;
    wait_valid(40, "accept_redir_next");
    check_instr("accept_redir_next", {4'hD, 4'hE, 8'h00, 1'b0, 12'h050});

    // Two redirects while draining: the last one wins
    enter_reset();
    mem[12'h222] = 8'hD8;
    lat_fixed = 3;
    release_at(12'h400);
    wait_req(20, "double");
    redirect_valid = 1'b1;
    redirect_addr = 12'h111;
    @(negedge CLK);
    redirect_addr = 12'h222;
    @(negedge CLK);
    redirect_valid = 1'b0;
    wait_valid(40, "double_out");
    check_instr("double_out", {4'hD, 4'h8, 8'h00, 1'b0, 12'h222});

    // Reset in the middle of a request
    enter_reset();
    lat_fixed = 5;
    release_at(12'h500);
    wait_req(20, "midreq");
    enter_reset();
    check_reset_outputs("midreq_reset");
    lat_fixed = 0;
    exp_q.delete();
    push_expect(12'h000);
    RESET = 1'b0;
    inject_stray = 1;
    @(negedge CLK);
    wait_valid(40, "midreq_out");
    check("midreq_out_pc", 32'(instr_pc), 32'h000);

`ifdef FETCH_BITREV_EN
    // Bit-reversed ROM byte
    enter_reset();
    mem[12'h600] = 8'hAB;
    release_at(12'h600);
    wait_valid(40, "bitrev");
    check("bitrev_opr_opa", 32'({instr_opr, instr_opa}), 32'hD5);
`endif

    // Random traffic: random ROM image, latency, back-pressure and redirects
    enter_reset();
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    lat_fixed = -1;
    exp_q.delete();
    push_expect(12'h000);
    handshakes = 0;
    RESET = 1'b0;
    rand_exec = 1;
    repeat (3000) @(negedge CLK);
    rand_exec = 0;
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    repeat (20) @(negedge CLK);
    check("random_progress", 32'(handshakes >= 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard against a stuck run
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
